leitor_7seg_bcd: RTL

Reads a multiplexed, active-high 7-segment display bus (segments a..g plus a one-hot digit-select) and recovers the BCD value of each digit. It is the inverse of our BCD-to-7-segment decoder chain and is used as an in-circuit monitor and self-check on display outputs. Each digit is captured only after its segment pattern has been stable for a programmable number of cycles. The block reports per-frame validity, invalid-pattern errors, and value-change events.

---
 rtl/leitor_7seg_bcd.sv | 138 +++++++++++++
 1 files changed

// File: rtl/leitor_7seg_bcd.sv
// rtl/leitor_7seg_bcd.sv - recovers per-digit BCD values from a multiplexed active-high 7-segment bus
module leitor_7seg_bcd #(
    parameter int N_DIG   = 4,
    parameter int ESTAVEL = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic                 d,
    input  logic                 e,
    input  logic                 f,
    input  logic                 g,
    input  logic [N_DIG-1:0]     an,
    output logic [4*N_DIG-1:0]   dig_bcd,
    output logic                 valido,
    output logic                 erro,
    output logic                 atualizado
);

    localparam int PW = N_DIG + 7;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [3:0] EST4 = 4'(ESTAVEL);

    logic [6:0]         seg;
    logic [PW-1:0]      pair;
    logic [PW-1:0]      pair_ant_q, pair_ant_d;
    logic [3:0]         cont_q, cont_d;
    logic               capturado_q, capturado_d;
    logic [4*N_DIG-1:0] dig_q, dig_d;
    logic [N_DIG-1:0]   mascara_q, mascara_d;
    logic               valido_q, valido_d;
    logic               erro_q, erro_d;
    logic               atualizado_q, atualizado_d;

    logic               qual;
    logic               held;
    logic               capture;
    logic [IW-1:0]      idx;
    logic               pat_ok;
    logic [3:0]         pat_nib;
    logic [3:0]         old_nib;

    assign seg = {a, b, c, d, e, f, g};

    always_comb begin
        pat_ok  = 1'b1;
        pat_nib = 4'd0;
        case (seg)
            7'b1111110: pat_nib = 4'd0;
            7'b0110000: pat_nib = 4'd1;
            7'b1101101: pat_nib = 4'd2;
            7'b1111001: pat_nib = 4'd3;
            7'b0110011: pat_nib = 4'd4;
            7'b1011011: pat_nib = 4'd5;
            7'b1011111: pat_nib = 4'd6;
            7'b1110000: pat_nib = 4'd7;
            7'b1111111: pat_nib = 4'd8;
            7'b1111011: pat_nib = 4'd9;
            default:    pat_ok  = 1'b0;
        endcase
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (an[i]) idx = IW'(i);
        end
    end

    always_comb begin
        pair         = {an, seg};
        qual         = ($countones(an) == 1) && (seg != 7'd0);
        pair_ant_d   = pair;
        cont_d       = 4'd0;
        capturado_d  = 1'b0;
        held         = 1'b0;
        capture      = 1'b0;
        dig_d        = dig_q;
        mascara_d    = mascara_q;
        valido_d     = &mascara_q;
        erro_d       = 1'b0;
        atualizado_d = 1'b0;
        old_nib      = dig_q[{idx, 2'b00} +: 4];

        // A changed pair opens a fresh window; an unchanged one inherits the window's capture flag.
        if (qual) begin
            if (pair != pair_ant_q) begin
                cont_d = 4'd1;
            end else begin
                cont_d = (cont_q >= EST4) ? EST4 : cont_q + 4'd1;
                held   = capturado_q;
            end
            capture     = (cont_d == EST4) && !held;
            capturado_d = held | capture;
        end

        if (capture) begin
            if (pat_ok) begin
                dig_d[{idx, 2'b00} +: 4] = pat_nib;
                mascara_d[idx]           = 1'b1;
                atualizado_d             = (pat_nib != old_nib) || !mascara_q[idx];
            end else begin
                mascara_d[idx] = 1'b0;
                erro_d         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_ant_q   <= '0;
            cont_q       <= 4'd0;
            capturado_q  <= 1'b0;
            dig_q        <= '0;
            mascara_q    <= '0;
            valido_q     <= 1'b0;
            erro_q       <= 1'b0;
            atualizado_q <= 1'b0;
        end else begin
            pair_ant_q   <= pair_ant_d;
            cont_q       <= cont_d;
            capturado_q  <= capturado_d;
            dig_q        <= dig_d;
            mascara_q    <= mascara_d;
            valido_q     <= valido_d;
            erro_q       <= erro_d;
            atualizado_q <= atualizado_d;
        end
    end

    assign dig_bcd    = dig_q;
    assign valido     = valido_q;
    assign erro       = erro_q;
    assign atualizado = atualizado_q;

endmodule
